// File: rtl/mcDefs.sv
`default_nettype none
// ---- mcDefs : shared types and bus geometry for proc_bus_master (rev 1.0) ----
package mcDefs;

  localparam int PAGE_W = 4;
  localparam int LOC_W  = 12;
  localparam int BUS_W  = 16;
  localparam int BEATS  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RWAIT = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } bus_state_t;

  typedef struct packed {
    logic                    rd;
    logic [PAGE_W-1:0]       page;
    logic [LOC_W-1:0]        loc;
    logic [BEATS*BUS_W-1:0]  wdata;
  } proc_req_t;

endpackage
`default_nettype wire

// File: rtl/burst_beat_ctr.sv
`default_nettype none
// ---- burst_beat_ctr : 2-bit burst beat counter with terminal-count flag (rev 1.0) ----
module burst_beat_ctr
  import mcDefs::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  output logic [1:0] beat,
  output logic       last
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat <= 2'd0;
    end else if (en) begin
      beat <= beat + 2'd1;
    end
  end

  assign last = (beat == LAST_BEAT);

endmodule
`default_nettype wire

// File: rtl/proc_bus_master.sv
`default_nettype none
// ---- proc_bus_master : CPU request to 4-beat multiplexed bus burst (rev 1.0) ----
module proc_bus_master
  import mcDefs::*;
#(
  parameter int RD_WAIT = 1
) (
  input  logic                   clk,
  input  logic                   resetH,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_rd,
  input  logic [PAGE_W-1:0]      req_page,
  input  logic [LOC_W-1:0]       req_loc,
  input  logic [BEATS*BUS_W-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [BEATS*BUS_W-1:0] rsp_rdata,
  output logic                   busy,
  output logic                   AddrValid,
  output logic                   rw_n,
  output logic [BUS_W-1:0]       AddrData_out,
  output logic                   AddrData_oe,
  input  logic [BUS_W-1:0]       AddrData_in
);

  bus_state_t state, state_nxt;
  proc_req_t  req_q;
  logic [2:0] wait_cnt;
  logic [1:0] beat;
  logic       beat_last;
  logic       accept;
  logic       wait_done;
  logic [(BEATS-1)*BUS_W-1:0] rd_buf;
  logic [BUS_W-1:0] bus_addr;
  logic       unused_loc_bits;

  // Word offset within the burst is dropped at latch time; bursts are 4-word aligned.
  assign unused_loc_bits = &{1'b0, req_loc[1:0]};

  assign req_ready = (state == IDLE) && !resetH;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign wait_done = (wait_cnt == 3'(RD_WAIT - 1));
  assign bus_addr  = {req_q.page, req_q.loc};

  burst_beat_ctr u_beat_ctr (
    .clk   (clk),
    .rst   (resetH),
    .clear (state == IDLE),
    .en    ((state == WDATA) || (state == RDATA)),
    .beat  (beat),
    .last  (beat_last)
  );

  always_ff @(posedge clk) begin
    if (resetH) begin
      state     <= IDLE;
      req_q     <= '0;
      wait_cnt  <= 3'd0;
      rd_buf    <= '0;
      rsp_rdata <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == RWAIT) ? wait_cnt + 3'd1 : 3'd0;
      if (accept) begin
        req_q.rd    <= req_rd;
        req_q.page  <= req_page;
        req_q.loc   <= {req_loc[LOC_W-1:2], 2'b00};
        req_q.wdata <= req_wdata;
      end
      // Read beats shift in from the top so beat 0 ends up as the low word.
      if (state == RDATA) begin
        rd_buf <= {AddrData_in, rd_buf[(BEATS-1)*BUS_W-1:BUS_W]};
        if (beat_last) begin
          rsp_rdata <= {AddrData_in, rd_buf};
        end
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    AddrValid    = 1'b0;
    rw_n         = 1'b1;
    AddrData_oe  = 1'b0;
    AddrData_out = '0;
    rsp_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = ADDR;
      end
      ADDR: begin
        AddrValid    = 1'b1;
        AddrData_oe  = 1'b1;
        AddrData_out = bus_addr;
        rw_n         = req_q.rd;
        state_nxt    = req_q.rd ? RWAIT : WDATA;
      end
      WDATA: begin
        AddrData_oe  = 1'b1;
        AddrData_out = req_q.wdata[{beat, 4'b0000} +: BUS_W];
        if (beat_last) state_nxt = RESP;
      end
      RWAIT: begin
        if (wait_done) state_nxt = RDATA;
      end
      RDATA: begin
        if (beat_last) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_proc_bus_master.sv
`default_nettype none
// ---- tb_proc_bus_master : directed vector bench for proc_bus_master (rev 1.0) ----
module tb_proc_bus_master;

  localparam int RD_WAIT = 1;

  logic        clk = 1'b0;
  logic        resetH;
  logic        req_valid;
  logic        req_ready;
  logic        req_rd;
  logic [3:0]  req_page;
  logic [11:0] req_loc;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        busy;
  logic        AddrValid;
  logic        rw_n;
  logic [15:0] AddrData_out;
  logic        AddrData_oe;
  logic [15:0] AddrData_in;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_rdata = 64'h0;

  typedef struct {
    logic             rd;
    logic [3:0]       page;
    logic [11:0]      loc;
    logic [63:0]      wdata;
    logic [15:0]      exp_addr;
    logic [3:0][15:0] words;
    logic [63:0]      exp_rdata;
  } vec_t;

  vec_t vecs [0:6];

  proc_bus_master #(.RD_WAIT(RD_WAIT)) dut (
    .clk          (clk),
    .resetH       (resetH),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rd       (req_rd),
    .req_page     (req_page),
    .req_loc      (req_loc),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
    .AddrValid    (AddrValid),
    .rw_n         (rw_n),
    .AddrData_out (AddrData_out),
    .AddrData_oe  (AddrData_oe),
    .AddrData_in  (AddrData_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " av"},    64'(AddrValid),    64'd0);
    check({tag, " oe"},    64'(AddrData_oe),  64'd0);
    check({tag, " out"},   64'(AddrData_out), 64'd0);
    check({tag, " rw_n"},  64'(rw_n),         64'd1);
    check({tag, " rsp"},   64'(rsp_valid),    64'd0);
    check({tag, " busy"},  64'(busy),         64'd0);
    check({tag, " rdata"}, rsp_rdata,         last_rdata);
  endtask

  // Called just after a rising edge. pre_acc: request already accepted at that edge.
  task automatic run_txn(input string tag, input vec_t v, input bit hold, input vec_t nxt,
                         input int abort_at, input bit pre_acc);
    int waited;
    int last_c;
    logic e_oe;
    logic [15:0] e_out;
    req_rd    = v.rd;
    req_page  = v.page;
    req_loc   = v.loc;
    req_wdata = v.wdata;
    if (pre_acc) begin
      req_valid = 1'b0;
    end else begin
      req_valid = 1'b1;
      waited = 0;
      forever begin
        @(negedge clk);
        if (req_ready) break;
        waited++;
        if (waited > 30) begin
          check({tag, " accept_timeout"}, 64'd0, 64'd1);
          req_valid = 1'b0;
          @(posedge clk); #1;
          return;
        end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
    last_c = v.rd ? 6 + RD_WAIT : 6;
    for (int c = 1; c <= last_c + 1; c++) begin
      if (v.rd && c >= 2 + RD_WAIT && c <= 5 + RD_WAIT) AddrData_in = v.words[c-2-RD_WAIT];
      else AddrData_in = 16'h5A5A;
      if (hold && c == 3) begin
        req_rd = nxt.rd; req_page = nxt.page; req_loc = nxt.loc; req_wdata = nxt.wdata;
        req_valid = 1'b1;
      end
      if (c == abort_at) resetH = 1'b1;
      @(negedge clk);
      e_oe  = (c == 1) || (!v.rd && c >= 2 && c <= 5);
      e_out = (c == 1) ? v.exp_addr : ((!v.rd && c >= 2 && c <= 5) ? v.words[c-2] : 16'h0);
      if (c == last_c && v.rd) last_rdata = v.exp_rdata;
      check($sformatf("%s c%0d av", tag, c),    64'(AddrValid),    64'(c == 1));
      check($sformatf("%s c%0d rw_n", tag, c),  64'(rw_n),         64'((c == 1) ? v.rd : 1'b1));
      check($sformatf("%s c%0d oe", tag, c),    64'(AddrData_oe),  64'(e_oe));
      check($sformatf("%s c%0d out", tag, c),   64'(AddrData_out), 64'(e_out));
      check($sformatf("%s c%0d rsp", tag, c),   64'(rsp_valid),    64'(c == last_c));
      check($sformatf("%s c%0d busy", tag, c),  64'(busy),         64'(c <= last_c));
      check($sformatf("%s c%0d ready", tag, c), 64'(req_ready),    64'((c == last_c + 1) && (c != abort_at)));
      check($sformatf("%s c%0d rdata", tag, c), rsp_rdata,         last_rdata);
      if (c == abort_at) begin
        @(posedge clk); #1;
        resetH = 1'b0;
        last_rdata = 64'h0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check_idle_outputs($sformatf("%s post_reset%0d", tag, k));
          check($sformatf("%s post_reset%0d ready", tag, k), 64'(req_ready), 64'd1);
          @(posedge clk); #1;
        end
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 4'h3, 12'h0A4, 64'h1111_2222_3333_4444, 16'h30A4,
                {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 64'h0};
    vecs[1] = '{1'b1, 4'hF, 12'hFFF, 64'h0, 16'hFFFC,
                {16'h4567, 16'h0123, 16'hDEAD, 16'hBEEF}, 64'h4567_0123_DEAD_BEEF};
    vecs[2] = '{1'b1, 4'h2, 12'h001, 64'h0, 16'h2000,
                {16'hABCD, 16'h1234, 16'hF00D, 16'hCAFE}, 64'hABCD_1234_F00D_CAFE};
    vecs[3] = '{1'b1, 4'h2, 12'h003, 64'h0, 16'h2000,
                {16'hABCD, 16'h1234, 16'hF00D, 16'hCAFE}, 64'hABCD_1234_F00D_CAFE};
    vecs[4] = '{1'b0, 4'h0, 12'h7FE, 64'h0123_4567_89AB_CDEF, 16'h07FC,
                {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}, 64'h0};
    vecs[5] = '{1'b0, 4'hA, 12'h550, 64'hDEAD_BEEF_0BAD_F00D, 16'hA550,
                {16'hDEAD, 16'hBEEF, 16'h0BAD, 16'hF00D}, 64'h0};
    vecs[6] = '{1'b1, 4'h1, 12'h234, 64'h0, 16'h1234,
                {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 64'h0004_0003_0002_0001};

    // Reset held with a pending request that must not be accepted.
    resetH      = 1'b1;
    req_valid   = 1'b1;
    req_rd      = 1'b0;
    req_page    = 4'h3;
    req_loc     = 12'h0A4;
    req_wdata   = 64'h1111_2222_3333_4444;
    AddrData_in = 16'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle_outputs($sformatf("reset%0d", k));
      check($sformatf("reset%0d ready", k), 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    resetH    = 1'b0;
    req_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i], 1'b0, vecs[0], 0, 1'b0);
    end

    // Second request raised during WDATA of the first.
    run_txn("hold_first", vecs[5], 1'b1, vecs[6], 0, 1'b0);
    run_txn("hold_second", vecs[6], 1'b0, vecs[0], 0, 1'b1);

    // Reset during the third read data beat, then a clean read.
    run_txn("abort_read", vecs[1], 1'b0, vecs[0], 4 + RD_WAIT, 1'b0);
    run_txn("after_abort", vecs[2], 1'b0, vecs[0], 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/proc_bus_master.md
Name: proc_bus_master

Overview:
- Sits directly downstream of the CPU stage and consumes its processor read/write requests (page, loc, 64-bit data).
- Converts each request into a single 4-beat burst on the 16-bit multiplexed main bus (AddrValid, rw_n, AddrData).
- Returns 64-bit read data, or a write-completion pulse, through a valid/ready request port and a one-cycle response pulse.

Parameters:
- PAGE_W, 4, page field width of the processor address
- LOC_W, 12, location field width (PAGE_W + LOC_W = BUS_W)
- BUS_W, 16, main bus AddrData width
- BEATS, 4, data beats per burst (BEATS * BUS_W = 64)
- RD_WAIT, 1, turnaround cycles between the read address beat and the first read data beat (legal range 1..7)

Ports:
- clk  in  1  main bus clock, all logic on rising edge
- resetH  in  1  synchronous, active-high reset
- req_valid  in  1  processor request present
- req_ready  out  1  block can accept a request this cycle
- req_rd  in  1  1 = read, 0 = write (same encoding as InstrType)
- req_page  in  PAGE_W  page field
- req_loc  in  LOC_W  location field
- req_wdata  in  64  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  64  read data, valid with rsp_valid on reads
- busy  out  1  transaction in flight (state != IDLE)
- AddrValid  out  1  address beat strobe
- rw_n  out  1  1 = read, 0 = write; meaningful while AddrValid = 1
- AddrData_out  out  BUS_W  address/data driven onto the bus
- AddrData_oe  out  1  master drives AddrData when 1
- AddrData_in  in  BUS_W  bus value sampled on read beats

Behaviour:
- Reset (resetH = 1 at a clock edge):
  - State goes to IDLE.
  - Outputs take these values: AddrValid = 0, rw_n = 1, AddrData_oe = 0, AddrData_out = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0.
  - req_ready = 0 while resetH is high.
- Reset mid-transaction: abort immediately with the reset values above. No rsp_valid is produced and the partial read buffer is discarded.
- Handshake:
  - req_ready = (state == IDLE) and not resetH.
  - A request is accepted on the edge where req_valid and req_ready are both 1. At that edge, rd, page, loc and wdata are latched.
  - Requests presented while busy are held off by req_ready = 0 and are never dropped or merged.
- Address: the bus address is {page, loc[LOC_W-1:2], 2'b00}. Bursts are always 4-word aligned and loc[1:0] is ignored.
- Data word order: beat k (k = 0..3) carries 64-bit bits [16k+15:16k], so the low word goes first.
- States:
  - IDLE: wait for an accepted request, then go to ADDR.
  - ADDR (1 cycle): AddrValid = 1, AddrData_oe = 1, AddrData_out = address, rw_n = rd. Go to WDATA if writing, RWAIT if reading.
  - WDATA (BEATS cycles): AddrData_oe = 1, AddrData_out = beat k, AddrValid = 0. A 2-bit beat counter wraps 3 -> 0 and exits to RESP.
  - RWAIT (RD_WAIT cycles): AddrData_oe = 0 (bus turnaround), then go to RDATA.
  - RDATA (BEATS cycles): sample AddrData_in into buffer word k at each edge, exit to RESP after beat 3.
  - RESP (1 cycle): rsp_valid = 1. On a read, rsp_rdata = assembled buffer; on a write, rsp_rdata holds its previous value. Next state is IDLE.
- Latency, with acceptance at edge T:
  - Write: ADDR in cycle T+1, data in T+2..T+5, rsp_valid in T+6.
  - Read: ADDR in T+1, data in T+2+RD_WAIT..T+5+RD_WAIT, rsp_valid in T+6+RD_WAIT.
- Back-to-back: req_ready returns in the cycle after RESP, so the minimum spacing between acceptances is 7 cycles (write) or 7+RD_WAIT cycles (read).
- AddrData_oe is never 1 during RWAIT or RDATA, so the master and memory never drive the bus in the same cycle.

Decomposition:
- Shared package (mcDefs):
  - bus_state_t enum {IDLE, ADDR, WDATA, RWAIT, RDATA, RESP}
  - proc_req_t struct {rd, page, loc, wdata}
  - constants BUS_W, BEATS, PAGE_W, LOC_W
- One natural sub-module, burst_beat_ctr: a 2-bit beat counter with a load/terminal-count flag, shared by WDATA and RDATA.
- Everything else lives in a single FSM plus datapath.

Test Plan:
- Reset: hold resetH for 3 cycles with req_valid = 1. Expect req_ready = 0, AddrValid = 0, AddrData_oe = 0, rsp_valid = 0 throughout.
- Write: page = 4'h3, loc = 12'h0A4, wdata = 64'h1111_2222_3333_4444. Expect:
  - ADDR beat 16'h30A4 with rw_n = 0;
  - data beats 4444, 3333, 2222, 1111;
  - rsp_valid at T+6.
- Read with RD_WAIT = 1: page = 4'hF, loc = 12'hFFF. Expect:
  - address 16'hFFFC with rw_n = 1;
  - model drives BEEF, DEAD, 0123, 4567;
  - rsp_rdata = 64'h4567_0123_DEAD_BEEF at T+7.
- Busy hold-off: assert a second request during WDATA of the first. Expect req_ready = 0 until the cycle after RESP, then acceptance and a correct second burst.
- Reset mid-read: assert resetH during the third RDATA beat. Expect no rsp_valid, bus outputs at reset values next edge, and a normal subsequent read.
- Aliasing: read with loc = 12'h001 vs loc = 12'h003. Expect an identical bus address 16'h..00 and identical rdata from the memory model.
